ffz_alloc: RTL and testbench

Parametrised slot allocator built on a find-first/last-zero search over a registered occupancy bitmap. Each alloc request claims one free slot and returns its index. Each free request releases one slot. The block replaces fixed-width ffz/flz trees with one width- and direction-generic search, and adds a "none free" indication in place of all-ones sentinel codes. It serves tag, register-rename and buffer-slot allocation throughout the core.

---
 rtl/ffz_alloc.sv | 133 +++++++++++++
 tb/tb_ffz_alloc.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ffz_alloc.sv
// Slot allocator: claims the lowest (MODE 0) or highest (MODE 1) free slot of a
// registered occupancy bitmap per alloc request, and releases slots on free requests.
module ffz_alloc #(
    parameter int              WID  = 96,
    parameter int              IDXW = $clog2(WID),
    parameter int              MODE = 0,
    parameter logic [WID-1:0]  INIT = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            alloc_req_i,
    output logic            alloc_ack_o,
    output logic            alloc_fail_o,
    output logic [IDXW-1:0] alloc_idx_o,
    input  logic            free_req_i,
    input  logic [IDXW-1:0] free_idx_i,
    output logic            free_err_o,
    output logic            full_o,
    output logic [IDXW:0]   count_o,
    output logic [WID-1:0]  bitmap_o
);

    localparam int NLEAF = (WID + 5) / 6;
    localparam int LVLS  = (NLEAF > 1) ? $clog2(NLEAF) : 0;
    localparam int NP    = 1 << LVLS;
    localparam int SRW   = NP * 6;

    logic [WID-1:0]  bitmap_q, bitmap_d;
    logic [IDXW:0]   count_q, count_d;
    logic            ack_q, ack_d;
    logic            fail_q, fail_d;
    logic            err_q, err_d;
    logic [IDXW-1:0] idx_q, idx_d;

    logic [SRW-1:0]  srch;
    logic            found;
    logic [IDXW-1:0] root_ix;
    logic [IDXW-1:0] srch_idx;
    logic            free_ok;
    logic            grant;

    // MODE 1 searches a bit-reversed copy so one lowest-zero tree serves both directions;
    // padding slots read as occupied and are never found.
    always_comb begin
        srch = '1;
        for (int i = 0; i < WID; i++) begin
            srch[i] = (MODE == 1) ? bitmap_q[WID-1-i] : bitmap_q[i];
        end
    end

    // Heap-ordered tree: 6-bit leaf encoders at NP..2NP-1, pairwise lower-half-wins above.
    always_comb begin
        logic            nf  [2*NP];
        logic [IDXW-1:0] nix [2*NP];
        for (int n = 0; n < 2 * NP; n++) begin
            nf[n]  = 1'b0;
            nix[n] = '0;
        end
        for (int g = 0; g < NP; g++) begin
            for (int k = 5; k >= 0; k--) begin
                if (!srch[g*6+k]) begin
                    nf[NP+g]  = 1'b1;
                    nix[NP+g] = IDXW'(g * 6 + k);
                end
            end
        end
        for (int n = NP - 1; n >= 1; n--) begin
            nf[n]  = nf[2*n] | nf[2*n+1];
            nix[n] = nf[2*n] ? nix[2*n] : nix[2*n+1];
        end
        found   = nf[1];
        root_ix = nix[1];
    end

    assign srch_idx = (MODE == 1) ? (IDXW'(WID - 1) - root_ix) : root_ix;

    assign grant   = alloc_req_i && found;
    assign free_ok = free_req_i && ({1'b0, free_idx_i} < (IDXW+1)'(WID)) && bitmap_q[free_idx_i];

    // The search sees the pre-free bitmap; a granted bit is zero and a legal free bit is one,
    // so both updates never touch the same slot.
    always_comb begin
        bitmap_d = bitmap_q;
        idx_d    = idx_q;
        ack_d    = 1'b0;
        fail_d   = 1'b0;
        err_d    = 1'b0;
        if (alloc_req_i) begin
            if (found) begin
                bitmap_d[srch_idx] = 1'b1;
                ack_d              = 1'b1;
                idx_d              = srch_idx;
            end else begin
                fail_d = 1'b1;
            end
        end
        if (free_req_i) begin
            if (free_ok) begin
                bitmap_d[free_idx_i] = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
        count_d = count_q + (IDXW+1)'(grant) - (IDXW+1)'(free_ok);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bitmap_q <= INIT;
            count_q  <= (IDXW+1)'($countones(INIT));
            ack_q    <= 1'b0;
            fail_q   <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= '0;
        end else begin
            bitmap_q <= bitmap_d;
            count_q  <= count_d;
            ack_q    <= ack_d;
            fail_q   <= fail_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
        end
    end

    assign alloc_ack_o  = ack_q;
    assign alloc_fail_o = fail_q;
    assign alloc_idx_o  = idx_q;
    assign free_err_o   = err_q;
    assign count_o      = count_q;
    assign bitmap_o     = bitmap_q;
    assign full_o       = &bitmap_q;

endmodule

// File: tb/tb_ffz_alloc.sv
// Bench for ffz_alloc: three instances (8-slot MODE 0, 96-slot MODE 1, 96-slot MODE 0)
// checked every cycle against a bit-array reference model, plus directed literal checks.
module tb_ffz_alloc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    localparam logic [95:0] INIT_B = {1'b1, 95'b0};
    localparam logic [95:0] INIT_C = 96'h8000_0000_0000_0100_0000_0003;

    logic       rst_n [3];
    logic       a_req [3];
    logic       f_req [3];
    logic [6:0] f_idx [3];

    // DUT A: 8 slots, lowest-zero
    logic       ack_a, fail_a, err_a, full_a;
    logic [2:0] idx_a;
    logic [3:0] cnt_a;
    logic [7:0] map_a;
    // DUT B: 96 slots, highest-zero, slot 95 reserved
    logic        ack_b, fail_b, err_b, full_b;
    logic [6:0]  idx_b;
    logic [7:0]  cnt_b;
    logic [95:0] map_b;
    // DUT C: 96 slots, lowest-zero, a few reserved slots
    logic        ack_c, fail_c, err_c, full_c;
    logic [6:0]  idx_c;
    logic [7:0]  cnt_c;
    logic [95:0] map_c;

    ffz_alloc #(.WID(8), .MODE(0), .INIT(8'h00)) u_a (
        .clk_i(clk), .rst_ni(rst_n[0]),
        .alloc_req_i(a_req[0]), .alloc_ack_o(ack_a), .alloc_fail_o(fail_a), .alloc_idx_o(idx_a),
        .free_req_i(f_req[0]), .free_idx_i(f_idx[0][2:0]), .free_err_o(err_a),
        .full_o(full_a), .count_o(cnt_a), .bitmap_o(map_a)
    );

    ffz_alloc #(.WID(96), .MODE(1), .INIT(INIT_B)) u_b (
        .clk_i(clk), .rst_ni(rst_n[1]),
        .alloc_req_i(a_req[1]), .alloc_ack_o(ack_b), .alloc_fail_o(fail_b), .alloc_idx_o(idx_b),
        .free_req_i(f_req[1]), .free_idx_i(f_idx[1]), .free_err_o(err_b),
        .full_o(full_b), .count_o(cnt_b), .bitmap_o(map_b)
    );

    ffz_alloc #(.WID(96), .MODE(0), .INIT(INIT_C)) u_c (
        .clk_i(clk), .rst_ni(rst_n[2]),
        .alloc_req_i(a_req[2]), .alloc_ack_o(ack_c), .alloc_fail_o(fail_c), .alloc_idx_o(idx_c),
        .free_req_i(f_req[2]), .free_idx_i(f_idx[2]), .free_err_o(err_c),
        .full_o(full_c), .count_o(cnt_c), .bitmap_o(map_c)
    );

    logic [95:0] o_map [3];
    logic [95:0] o_idx [3];
    logic [95:0] o_cnt [3];
    logic        o_ack [3];
    logic        o_fail [3];
    logic        o_err [3];
    logic        o_full [3];

    assign o_map[0] = {88'b0, map_a};
    assign o_map[1] = map_b;
    assign o_map[2] = map_c;
    assign o_idx[0] = {93'b0, idx_a};
    assign o_idx[1] = {89'b0, idx_b};
    assign o_idx[2] = {89'b0, idx_c};
    assign o_cnt[0] = {92'b0, cnt_a};
    assign o_cnt[1] = {88'b0, cnt_b};
    assign o_cnt[2] = {88'b0, cnt_c};
    assign o_ack[0] = ack_a;   assign o_ack[1] = ack_b;   assign o_ack[2] = ack_c;
    assign o_fail[0] = fail_a; assign o_fail[1] = fail_b; assign o_fail[2] = fail_c;
    assign o_err[0] = err_a;   assign o_err[1] = err_b;   assign o_err[2] = err_c;
    assign o_full[0] = full_a; assign o_full[1] = full_b; assign o_full[2] = full_c;

    // ---------------- reference model ----------------
    logic [95:0] m_map [3];
    int          e_idx [3];
    logic        e_ack [3];
    logic        e_fail [3];
    logic        e_err [3];

    function automatic int wid_of(int d);
        return (d == 0) ? 8 : 96;
    endfunction

    function automatic logic [95:0] init_of(int d);
        if (d == 1) return INIT_B;
        if (d == 2) return INIT_C;
        return 96'b0;
    endfunction

    // Returns the slot to grant, or -1 when every slot is taken.
    function automatic int pick_slot(logic [95:0] m, int w, bit highest);
        int r;
        r = -1;
        if (!highest) begin
            for (int i = 0; i < w; i++) if (!m[i] && r < 0) r = i;
        end else begin
            for (int i = w - 1; i >= 0; i--) if (!m[i] && r < 0) r = i;
        end
        return r;
    endfunction

    function automatic logic [95:0] used_mask(int w);
        logic [95:0] m;
        m = '0;
        for (int i = 0; i < w; i++) m[i] = 1'b1;
        return m;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            logic [95:0] old;
            int          k;
            int          fi;
            if (!rst_n[d]) begin
                m_map[d]  = init_of(d);
                e_idx[d]  = 0;
                e_ack[d]  = 1'b0;
                e_fail[d] = 1'b0;
                e_err[d]  = 1'b0;
            end else begin
                old       = m_map[d];
                e_ack[d]  = 1'b0;
                e_fail[d] = 1'b0;
                e_err[d]  = 1'b0;
                if (a_req[d]) begin
                    k = pick_slot(old, wid_of(d), d == 1);
                    if (k >= 0) begin
                        m_map[d][k] = 1'b1;
                        e_ack[d]    = 1'b1;
                        e_idx[d]    = k;
                    end else begin
                        e_fail[d] = 1'b1;
                    end
                end
                if (f_req[d]) begin
                    fi = int'(f_idx[d]);
                    if (fi < wid_of(d) && old[fi]) m_map[d][fi] = 1'b0;
                    else e_err[d] = 1'b1;
                end
            end
        end
        chk_on = 1'b1;
    end

    task automatic chk(input string nm, input int d, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 3; d++) begin
                logic [95:0] msk;
                msk = used_mask(wid_of(d));
                chk("ack", d, {95'b0, o_ack[d]}, {95'b0, e_ack[d]});
                chk("fail", d, {95'b0, o_fail[d]}, {95'b0, e_fail[d]});
                chk("free_err", d, {95'b0, o_err[d]}, {95'b0, e_err[d]});
                chk("idx", d, o_idx[d], 96'(e_idx[d]));
                chk("bitmap", d, o_map[d], m_map[d]);
                chk("count", d, o_cnt[d], 96'($countones(m_map[d])));
                chk("full", d, {95'b0, o_full[d]}, {95'b0, ((m_map[d] & msk) == msk)});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int ptab [4];
        int p;
        ptab = '{85, 50, 15, 97};
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0;
            a_req[d] = 1'b0;
            f_req[d] = 1'b0;
            f_idx[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        chk("rst_map_a", 0, o_map[0], 96'h0);
        chk("rst_cnt_b", 1, o_cnt[1], 96'd1);
        chk("rst_cnt_c", 2, o_cnt[2], 96'd4);
        chk("rst_idx_b", 1, o_idx[1], 96'd0);

        // fill 8 slots in ascending order, then one more fails
        a_req[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("fill_ack", 0, {95'b0, o_ack[0]}, 96'd1);
            chk("fill_idx", 0, o_idx[0], 96'(i));
        end
        chk("fill_full", 0, {95'b0, o_full[0]}, 96'd1);
        chk("fill_cnt", 0, o_cnt[0], 96'd8);
        @(negedge clk);
        chk("full_fail", 0, {95'b0, o_fail[0]}, 96'd1);
        chk("full_map", 0, o_map[0], 96'hFF);

        // alloc while full plus legal free of slot 3
        f_req[0] = 1'b1;
        f_idx[0] = 7'd3;
        @(negedge clk);
        chk("simul_fail", 0, {95'b0, o_fail[0]}, 96'd1);
        chk("simul_map", 0, o_map[0], 96'hF7);
        chk("simul_cnt", 0, o_cnt[0], 96'd7);
        f_req[0] = 1'b0;
        @(negedge clk);
        chk("refill_idx", 0, o_idx[0], 96'd3);
        chk("refill_cnt", 0, o_cnt[0], 96'd8);

        // legal free of 5, then freeing 5 again is an error
        a_req[0] = 1'b0;
        f_req[0] = 1'b1;
        f_idx[0] = 7'd5;
        @(negedge clk);
        chk("free_ok", 0, {95'b0, o_err[0]}, 96'd0);
        chk("free_map", 0, o_map[0], 96'hDF);
        @(negedge clk);
        chk("free_twice_err", 0, {95'b0, o_err[0]}, 96'd1);
        chk("free_twice_map", 0, o_map[0], 96'hDF);
        chk("free_twice_cnt", 0, o_cnt[0], 96'd7);

        // reset in the middle of an alloc burst
        a_req[0] = 1'b1;
        f_idx[0] = 7'd0;
        @(negedge clk);
        chk("burst_idx", 0, o_idx[0], 96'd5);
        chk("burst_map", 0, o_map[0], 96'hFE);
        f_req[0] = 1'b0;
        rst_n[0] = 1'b0;
        @(negedge clk);
        chk("midrst_ack", 0, {95'b0, o_ack[0]}, 96'd0);
        chk("midrst_map", 0, o_map[0], 96'h0);
        chk("midrst_cnt", 0, o_cnt[0], 96'd0);
        rst_n[0] = 1'b1;
        @(negedge clk);
        chk("postrst_idx", 0, o_idx[0], 96'd0);
        a_req[0] = 1'b0;

        // MODE 1 with slot 95 reserved
        a_req[1] = 1'b1;
        @(negedge clk);
        chk("m1_idx0", 1, o_idx[1], 96'd94);
        chk("m1_cnt0", 1, o_cnt[1], 96'd2);
        @(negedge clk);
        chk("m1_idx1", 1, o_idx[1], 96'd93);
        chk("m1_cnt1", 1, o_cnt[1], 96'd3);
        a_req[1] = 1'b0;

        // out-of-range free
        f_req[2] = 1'b1;
        f_idx[2] = 7'd100;
        @(negedge clk);
        chk("oor_err", 2, {95'b0, o_err[2]}, 96'd1);
        chk("oor_cnt", 2, o_cnt[2], 96'd4);
        f_req[2] = 1'b0;

        // random soak on both 96-slot instances, with fill/drain phases
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            p = ptab[(cyc / 600) % 4];
            for (int d = 1; d < 3; d++) begin
                a_req[d] = ($urandom_range(99) < p);
                f_req[d] = ($urandom_range(99) < (105 - p));
                f_idx[d] = (d == 2) ? 7'($urandom_range(127)) : 7'($urandom_range(95));
                rst_n[d] = ($urandom_range(2999) != 0);
            end
        end
        for (int d = 0; d < 3; d++) begin
            a_req[d] = 1'b0;
            f_req[d] = 1'b0;
            rst_n[d] = 1'b1;
        end
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
